seq_decoder: RTL and testbench
==============================

SEQ_DECODER -- requirements
Module: seq_decoder

Interface
REQ-001 The block SHALL have parameter LAP_W, default 8: lap counter width, legal 2..16.
REQ-002 The block SHALL have parameter ERR_W, default 4: error counter width, legal 1..16.
REQ-003 The block SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port state_in, input, 2: 2-bit sequencer state under observation, synchronous to clk.
REQ-006 The block SHALL have port clear, input, 1: synchronous clear of counters and lock.
REQ-007 The block SHALL have port locked, output, 1: high while the decoder tracks the sequence.
REQ-008 The block SHALL have port step, output, 1: one-cycle pulse per legal advance.
REQ-009 The block SHALL have port lap, output, 1: one-cycle pulse per legal 11->00 wrap.
REQ-010 The block SHALL have port err, output, 1: one-cycle pulse per illegal transition.
REQ-011 The block SHALL have port fault, output, 1: sticky fault flag (see Configuration).
REQ-012 The block SHALL have port cur_state, output, 2: last accepted state.
REQ-013 The block SHALL have ports lap_count (LAP_W) and err_count (ERR_W), outputs: event counters.

Function
REQ-014 The block SHALL implement FSM states UNLOCKED, LOCKED and FAULT, and SHALL keep a 2-bit register prev_q.
REQ-015 In UNLOCKED, when a sampled state_in equals 2'b00, the block SHALL load prev_q=00 and enter LOCKED; any other value SHALL keep it in UNLOCKED with no pulses.
REQ-016 In LOCKED, when state_in equals prev_q, the block SHALL produce no pulse and no counter change.
REQ-017 In LOCKED, when state_in equals (prev_q+1) mod 4, the block SHALL assert step and update prev_q to state_in.
REQ-018 In LOCKED, when prev_q=11 and state_in=00, the block SHALL additionally assert lap and increment lap_count.
REQ-019 In LOCKED, any other transition (+2 or +3 mod 4) SHALL assert err, increment err_count and set prev_q to state_in.
REQ-020 All pulses SHALL be registered: they are high exactly one cycle, in the cycle following the edge that sampled the transition; counters SHALL update on that same edge.
REQ-021 lap_count and err_count SHALL saturate at all-ones and never wrap.
REQ-022 clear SHALL take priority over all other events in the same cycle: it zeroes both counters, returns the FSM to UNLOCKED, clears fault and suppresses pulses at that edge.
REQ-023 The locked output SHALL be high in LOCKED only; cur_state SHALL equal prev_q.
REQ-024 step, lap and err SHALL never be asserted in UNLOCKED or FAULT.

Reset
REQ-025 While reset is high, the block SHALL hold the FSM in UNLOCKED with prev_q=00, cur_state=00, locked=0, step=0, lap=0, err=0, fault=0, lap_count=0 and err_count=0.
REQ-026 Reset asserted mid-sequence SHALL discard all tracking; after release, the block SHALL relock only on the next sampled 00.

Configuration
REQ-027 With macro SEQ_DECODER_STICKY_ERR_EN defined, an illegal transition SHALL still pulse err and count, then move the FSM to FAULT with fault=1 and locked=0; FAULT SHALL be exited only by clear or reset.
REQ-028 Without SEQ_DECODER_STICKY_ERR_EN, the FSM SHALL stay in LOCKED after an illegal transition, the FAULT state SHALL be absent, and fault SHALL be tied to 0.

Verification
REQ-029 Reset release, state_in=00 for 2 cycles, then 01,10,11,00 -> locked=1, four step pulses, one lap pulse coincident with the 4th step, lap_count=1, err_count=0.
REQ-030 Locked at 01, state_in jumps to 11 -> err pulse, err_count=1, cur_state=11; without the macro a following 00 gives step+lap; with the macro fault=1, locked=0 and no further pulses.
REQ-031 Drive 300 legal laps with LAP_W=8 -> lap_count saturates at 255 and lap keeps pulsing.
REQ-032 Assert clear in the same cycle as a legal 11->00 -> no lap pulse, lap_count=0, locked=0; relock on the next 00.
REQ-033 Assert reset while at cur_state=10 with lap_count=5, release with state_in=10 -> all outputs 0, stays UNLOCKED until state_in=00.
REQ-034 Hold state_in=10 for 20 cycles after reset -> locked stays 0 and no pulses occur.

Source files
------------

// File: rtl/seq_decoder_if.sv
// Observation bus of seq_decoder: sampled sequencer state and clear in,
// lock/pulse/counter status out.
interface seq_decoder_if #(
  parameter int LAP_W = 8,
  parameter int ERR_W = 4
);
  logic [1:0]       state_in;
  logic             clear;
  logic             locked;
  logic             step;
  logic             lap;
  logic             err;
  logic             fault;
  logic [1:0]       cur_state;
  logic [LAP_W-1:0] lap_count;
  logic [ERR_W-1:0] err_count;

  modport master (
    output state_in, clear,
    input  locked, step, lap, err, fault, cur_state, lap_count, err_count
  );

  modport slave (
    input  state_in, clear,
    output locked, step, lap, err, fault, cur_state, lap_count, err_count
  );
endinterface

// File: rtl/seq_decoder.sv
// seq_decoder: tracks a 2-bit cyclic sequencer, pulses step/lap/err, counts laps/errors; SEQ_DECODER_STICKY_ERR_EN adds a sticky FAULT state.
// Latency: pulses and counters are registered, one cycle after the sampling edge; no backpressure, every cycle is observed.
module seq_decoder #(
  parameter int LAP_W = 8,
  parameter int ERR_W = 4
) (
  input  logic         clk,
  input  logic         reset,
  seq_decoder_if.slave bus
);

`ifdef SEQ_DECODER_STICKY_ERR_EN
  typedef enum logic [1:0] {UNLOCKED = 2'd0, LOCKED = 2'd1, FAULT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {UNLOCKED = 2'd0, LOCKED = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [1:0]       prev_q, prev_d;
  logic [1:0]       delta;
  logic             step_q, step_d;
  logic             lap_q, lap_d;
  logic             err_q, err_d;
  logic [LAP_W-1:0] lap_cnt_q, lap_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= UNLOCKED;
      prev_q    <= 2'b00;
      step_q    <= 1'b0;
      lap_q     <= 1'b0;
      err_q     <= 1'b0;
      lap_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      step_q    <= step_d;
      lap_q     <= lap_d;
      err_q     <= err_d;
      lap_cnt_q <= lap_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    step_d    = 1'b0;
    lap_d     = 1'b0;
    err_d     = 1'b0;
    lap_cnt_d = lap_cnt_q;
    err_cnt_d = err_cnt_q;
    // Modular distance from the last accepted state: 0 hold, 1 advance, 2/3 illegal.
    delta     = bus.state_in - prev_q;

    if (bus.clear) begin
      state_d   = UNLOCKED;
      prev_d    = 2'b00;
      lap_cnt_d = '0;
      err_cnt_d = '0;
    end else begin
      case (state_q)
        UNLOCKED: begin
          if (bus.state_in == 2'b00) begin
            prev_d  = 2'b00;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (delta == 2'd1) begin
            step_d = 1'b1;
            prev_d = bus.state_in;
            if (prev_q == 2'b11) begin
              lap_d = 1'b1;
              if (lap_cnt_q != '1) lap_cnt_d = lap_cnt_q + 1'b1;
            end
          end else if (delta != 2'd0) begin
            err_d  = 1'b1;
            prev_d = bus.state_in;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
`ifdef SEQ_DECODER_STICKY_ERR_EN
            state_d = FAULT;
`endif
          end
        end
`ifdef SEQ_DECODER_STICKY_ERR_EN
        FAULT: state_d = FAULT;
`endif
        default: state_d = UNLOCKED;
      endcase
    end
  end

  assign bus.locked    = (state_q == LOCKED);
  assign bus.step      = step_q;
  assign bus.lap       = lap_q;
  assign bus.err       = err_q;
  assign bus.cur_state = prev_q;
  assign bus.lap_count = lap_cnt_q;
  assign bus.err_count = err_cnt_q;
`ifdef SEQ_DECODER_STICKY_ERR_EN
  assign bus.fault     = (state_q == FAULT);
`else
  assign bus.fault     = 1'b0;
`endif

endmodule

// File: tb/tb_seq_decoder.sv
// Directed vector table plus hand-written multi-cycle sequences for seq_decoder.
module tb_seq_decoder;
  localparam int LAP_W = 8;
  localparam int ERR_W = 4;
  localparam int NV    = 25;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_decoder_if #(.LAP_W(LAP_W), .ERR_W(ERR_W)) bus ();

  seq_decoder #(.LAP_W(LAP_W), .ERR_W(ERR_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        rst;
    logic        clr;
    logic [1:0]  si;
    logic [18:0] exp;
  } vec_t;

  vec_t tbl [NV];

  // Output bundle: locked, step, lap, err, fault, cur_state, lap_count, err_count.
  function automatic logic [18:0] pk(input logic l, input logic s, input logic p,
                                     input logic e, input logic f, input logic [1:0] cs,
                                     input logic [7:0] lc, input logic [3:0] ec);
    return {l, s, p, e, f, cs, lc, ec};
  endfunction

  function automatic logic [18:0] act();
    return {bus.locked, bus.step, bus.lap, bus.err, bus.fault,
            bus.cur_state, bus.lap_count, bus.err_count};
  endfunction

  task automatic check(input string nm, input logic [18:0] got, input logic [18:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got L%b S%b P%b E%b F%b cs=%b lc=%0d ec=%0d, want L%b S%b P%b E%b F%b cs=%b lc=%0d ec=%0d",
                  nm, got[18], got[17], got[16], got[15], got[14], got[13:12], got[11:4], got[3:0],
                  exp[18], exp[17], exp[16], exp[15], exp[14], exp[13:12], exp[11:4], exp[3:0]);
  endtask

  task automatic cyc(input logic rst, input logic clr, input logic [1:0] si);
    @(negedge clk);
    reset        = rst;
    bus.clear    = clr;
    bus.state_in = si;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    bus.clear    = 1'b0;
    bus.state_in = 2'b00;

    tbl[0]  = '{1'b1, 1'b0, 2'd0, pk(0,0,0,0,0,2'd0,8'd0,4'd0)};
    tbl[1]  = '{1'b0, 1'b0, 2'd0, pk(1,0,0,0,0,2'd0,8'd0,4'd0)};
    tbl[2]  = '{1'b0, 1'b0, 2'd0, pk(1,0,0,0,0,2'd0,8'd0,4'd0)};
    tbl[3]  = '{1'b0, 1'b0, 2'd1, pk(1,1,0,0,0,2'd1,8'd0,4'd0)};
    tbl[4]  = '{1'b0, 1'b0, 2'd2, pk(1,1,0,0,0,2'd2,8'd0,4'd0)};
    tbl[5]  = '{1'b0, 1'b0, 2'd3, pk(1,1,0,0,0,2'd3,8'd0,4'd0)};
    tbl[6]  = '{1'b0, 1'b0, 2'd0, pk(1,1,1,0,0,2'd0,8'd1,4'd0)};
    tbl[7]  = '{1'b0, 1'b0, 2'd1, pk(1,1,0,0,0,2'd1,8'd1,4'd0)};
`ifdef SEQ_DECODER_STICKY_ERR_EN
    tbl[8]  = '{1'b0, 1'b0, 2'd3, pk(0,0,0,1,1,2'd3,8'd1,4'd1)};
    tbl[9]  = '{1'b0, 1'b0, 2'd0, pk(0,0,0,0,1,2'd3,8'd1,4'd1)};
`else
    tbl[8]  = '{1'b0, 1'b0, 2'd3, pk(1,0,0,1,0,2'd3,8'd1,4'd1)};
    tbl[9]  = '{1'b0, 1'b0, 2'd0, pk(1,1,1,0,0,2'd0,8'd2,4'd1)};
`endif
    tbl[10] = '{1'b0, 1'b1, 2'd1, pk(0,0,0,0,0,2'd0,8'd0,4'd0)};
    tbl[11] = '{1'b0, 1'b0, 2'd2, pk(0,0,0,0,0,2'd0,8'd0,4'd0)};
    tbl[12] = '{1'b0, 1'b0, 2'd0, pk(1,0,0,0,0,2'd0,8'd0,4'd0)};
`ifdef SEQ_DECODER_STICKY_ERR_EN
    tbl[13] = '{1'b0, 1'b0, 2'd3, pk(0,0,0,1,1,2'd3,8'd0,4'd1)};
`else
    tbl[13] = '{1'b0, 1'b0, 2'd3, pk(1,0,0,1,0,2'd3,8'd0,4'd1)};
`endif
    tbl[14] = '{1'b0, 1'b1, 2'd0, pk(0,0,0,0,0,2'd0,8'd0,4'd0)};
    tbl[15] = '{1'b0, 1'b0, 2'd0, pk(1,0,0,0,0,2'd0,8'd0,4'd0)};
    tbl[16] = '{1'b0, 1'b0, 2'd1, pk(1,1,0,0,0,2'd1,8'd0,4'd0)};
    tbl[17] = '{1'b0, 1'b0, 2'd2, pk(1,1,0,0,0,2'd2,8'd0,4'd0)};
    tbl[18] = '{1'b0, 1'b0, 2'd3, pk(1,1,0,0,0,2'd3,8'd0,4'd0)};
    tbl[19] = '{1'b0, 1'b1, 2'd0, pk(0,0,0,0,0,2'd0,8'd0,4'd0)};
    tbl[20] = '{1'b0, 1'b0, 2'd0, pk(1,0,0,0,0,2'd0,8'd0,4'd0)};
    tbl[21] = '{1'b0, 1'b0, 2'd1, pk(1,1,0,0,0,2'd1,8'd0,4'd0)};
    tbl[22] = '{1'b1, 1'b0, 2'd1, pk(0,0,0,0,0,2'd0,8'd0,4'd0)};
    tbl[23] = '{1'b0, 1'b0, 2'd1, pk(0,0,0,0,0,2'd0,8'd0,4'd0)};
    tbl[24] = '{1'b0, 1'b0, 2'd0, pk(1,0,0,0,0,2'd0,8'd0,4'd0)};

    for (int i = 0; i < NV; i++) begin
      cyc(tbl[i].rst, tbl[i].clr, tbl[i].si);
      check($sformatf("vec%0d", i), act(), tbl[i].exp);
    end

    // Holding a non-zero state after reset never locks.
    cyc(1'b1, 1'b0, 2'd2);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 2'd2);
      check($sformatf("hold10_%0d", i), act(), pk(0,0,0,0,0,2'd0,8'd0,4'd0));
    end

    // 300 legal laps: counter saturates at 255, lap keeps pulsing.
    cyc(1'b1, 1'b0, 2'd0);
    cyc(1'b0, 1'b0, 2'd0);
    for (int n = 1; n <= 300; n++) begin
      cyc(1'b0, 1'b0, 2'd1);
      cyc(1'b0, 1'b0, 2'd2);
      cyc(1'b0, 1'b0, 2'd3);
      cyc(1'b0, 1'b0, 2'd0);
      check($sformatf("lap%0d", n), act(),
            pk(1,1,1,0,0,2'd0,(n > 255) ? 8'd255 : 8'(n),4'd0));
    end

    // Asynchronous reset mid-sequence at cur_state=10, lap_count=5.
    cyc(1'b1, 1'b0, 2'd0);
    cyc(1'b0, 1'b0, 2'd0);
    for (int n = 0; n < 5; n++) begin
      cyc(1'b0, 1'b0, 2'd1);
      cyc(1'b0, 1'b0, 2'd2);
      cyc(1'b0, 1'b0, 2'd3);
      cyc(1'b0, 1'b0, 2'd0);
    end
    cyc(1'b0, 1'b0, 2'd1);
    cyc(1'b0, 1'b0, 2'd2);
    check("pre_reset", act(), pk(1,1,0,0,0,2'd2,8'd5,4'd0));
    #2 reset = 1'b1;
    #1 check("async_reset", act(), pk(0,0,0,0,0,2'd0,8'd0,4'd0));
    cyc(1'b1, 1'b0, 2'd2);
    cyc(1'b0, 1'b0, 2'd2);
    check("post_reset_a", act(), pk(0,0,0,0,0,2'd0,8'd0,4'd0));
    cyc(1'b0, 1'b0, 2'd2);
    check("post_reset_b", act(), pk(0,0,0,0,0,2'd0,8'd0,4'd0));
    cyc(1'b0, 1'b0, 2'd0);
    check("relock", act(), pk(1,0,0,0,0,2'd0,8'd0,4'd0));

    // Illegal transitions: saturating error count, or sticky fault.
    cyc(1'b1, 1'b0, 2'd0);
    cyc(1'b0, 1'b0, 2'd0);
`ifdef SEQ_DECODER_STICKY_ERR_EN
    cyc(1'b0, 1'b0, 2'd2);
    check("fault_enter", act(), pk(0,0,0,1,1,2'd2,8'd0,4'd1));
    cyc(1'b0, 1'b0, 2'd3);
    check("fault_hold_a", act(), pk(0,0,0,0,1,2'd2,8'd0,4'd1));
    cyc(1'b0, 1'b0, 2'd0);
    check("fault_hold_b", act(), pk(0,0,0,0,1,2'd2,8'd0,4'd1));
    cyc(1'b0, 1'b1, 2'd0);
    check("fault_clear", act(), pk(0,0,0,0,0,2'd0,8'd0,4'd0));
    cyc(1'b0, 1'b0, 2'd0);
    check("fault_relock", act(), pk(1,0,0,0,0,2'd0,8'd0,4'd0));
`else
    for (int i = 1; i <= 30; i++) begin
      cyc(1'b0, 1'b0, (i % 2 == 1) ? 2'd2 : 2'd0);
      check($sformatf("err%0d", i), act(),
            pk(1,0,0,1,0,(i % 2 == 1) ? 2'd2 : 2'd0,8'd0,(i > 15) ? 4'd15 : 4'(i)));
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
